sap1_controller_sequencer: RTL and testbench

- Control/sequencer unit for the SAP-1 datapath: a 6-phase T-state ring counter plus an instruction decoder.
- Drives the per-cycle control word for the program counter (cp, ep), MAR, RAM, IR, accumulator, adder/subtractor, B register and output register.
- Only block that sequences the shared W bus; guarantees one bus driver per cycle.
- All datapath registers sample on the same clk rising edge as this block.

---
 rtl/sap1_controller_sequencer.sv | 152 +++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control/sequencer: six-phase T-state ring plus instruction decode for the W-bus datapath.
// Optional SAP1_SINGLE_STEP_EN adds a 'step' input that advances the ring one state per rising edge.
//
// state  | meaning
// IDLE   | after reset, waiting for the first fetch
// T1     | PC -> MAR
// T2     | PC increment
// T3     | RAM -> IR
// T4..T6 | execute phases, decoded from ir_opcode
// HALT   | HLT executed, held until reset
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] ir_opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [11:0] C_CP = 12'b1000_0000_0000;
    localparam logic [11:0] C_EP = 12'b0100_0000_0000;
    localparam logic [11:0] C_LM = 12'b0010_0000_0000;
    localparam logic [11:0] C_CE = 12'b0001_0000_0000;
    localparam logic [11:0] C_LI = 12'b0000_1000_0000;
    localparam logic [11:0] C_EI = 12'b0000_0100_0000;
    localparam logic [11:0] C_LA = 12'b0000_0010_0000;
    localparam logic [11:0] C_EA = 12'b0000_0001_0000;
    localparam logic [11:0] C_SU = 12'b0000_0000_1000;
    localparam logic [11:0] C_EU = 12'b0000_0000_0100;
    localparam logic [11:0] C_LB = 12'b0000_0000_0010;
    localparam logic [11:0] C_LO = 12'b0000_0000_0001;

    state_t      state, state_nxt;
    logic        advance;
    logic        out_en;
    logic [11:0] ctrl;

`ifdef SAP1_SINGLE_STEP_EN
    logic step_q, step_prev, fire;

    assign fire    = step_q & ~step_prev;
    assign advance = fire;

    // Control word is shown only in the cycle right after an advance so each step pulses cp once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q    <= 1'b0;
            step_prev <= 1'b0;
            out_en    <= 1'b0;
        end else begin
            step_q    <= step;
            step_prev <= step_q;
            out_en    <= fire;
        end
    end
`else
    assign advance = 1'b1;
    assign out_en  = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else if (advance)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = S_T4;
            S_T4:   state_nxt = (ir_opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:   state_nxt = S_T6;
            S_T6:   state_nxt = S_T1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_T1: ctrl = C_EP | C_LM;
            S_T2: ctrl = C_CP;
            S_T3: ctrl = C_CE | C_LI;
            S_T4: begin
                if (ir_opcode == OP_LDA || ir_opcode == OP_ADD || ir_opcode == OP_SUB)
                    ctrl = C_EI | C_LM;
                else if (ir_opcode == OP_OUT)
                    ctrl = C_EA | C_LO;
            end
            S_T5: begin
                if (ir_opcode == OP_LDA)
                    ctrl = C_CE | C_LA;
                else if (ir_opcode == OP_ADD || ir_opcode == OP_SUB)
                    ctrl = C_CE | C_LB;
            end
            S_T6: begin
                if (ir_opcode == OP_ADD)
                    ctrl = C_EU | C_LA;
                else if (ir_opcode == OP_SUB)
                    ctrl = C_SU | C_EU | C_LA;
            end
            default: ctrl = '0;
        endcase
    end

    assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = out_en ? ctrl : 12'b0;

    always_comb begin
        t_state = 6'b000000;
        case (state)
            S_T1: t_state = 6'b000001;
            S_T2: t_state = 6'b000010;
            S_T3: t_state = 6'b000100;
            S_T4: t_state = 6'b001000;
            S_T5: t_state = 6'b010000;
            S_T6: t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Scoreboard bench for sap1_controller_sequencer; with SAP1_SINGLE_STEP_EN defined it exercises step mode only.
module tb_sap1_controller_sequencer;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;
    localparam logic [3:0] NOP = 4'b0111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ir_opcode = 4'b0000;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic [5:0] t_state;
    logic       halted;
`ifdef SAP1_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [18:0] sb_q[$];
    logic [18:0] exp_w;

    wire [11:0] ctrl_obs = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    wire [18:0] obs      = {halted, t_state, ctrl_obs};

    sap1_controller_sequencer dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SAP1_SINGLE_STEP_EN
        .step      (step),
`endif
        .ir_opcode (ir_opcode),
        .cp        (cp),
        .ep        (ep),
        .lm        (lm),
        .ce        (ce),
        .li        (li),
        .ei        (ei),
        .la        (la),
        .ea        (ea),
        .su        (su),
        .eu        (eu),
        .lb        (lb),
        .lo        (lo),
        .t_state   (t_state),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Control word order: cp ep lm ce li ei la ea su eu lb lo
    function automatic logic [11:0] exp_ctrl(input logic [3:0] op, input int t);
        logic [11:0] c;
        c = 12'b0;
        if (t == 1) c = 12'b0110_0000_0000;
        if (t == 2) c = 12'b1000_0000_0000;
        if (t == 3) c = 12'b0001_1000_0000;
        if (t == 4 && (op == LDA || op == ADD || op == SUB)) c = 12'b0010_0100_0000;
        if (t == 4 && op == OUT) c = 12'b0000_0001_0001;
        if (t == 5 && op == LDA) c = 12'b0001_0010_0000;
        if (t == 5 && (op == ADD || op == SUB)) c = 12'b0001_0000_0010;
        if (t == 6 && op == ADD) c = 12'b0000_0010_0100;
        if (t == 6 && op == SUB) c = 12'b0000_0010_1100;
        return c;
    endfunction

    function automatic logic [18:0] exp_word(input logic [3:0] op, input int t);
        logic [5:0] oh;
        oh = 6'b000001;
        oh = oh << (t - 1);
        return {1'b0, oh, exp_ctrl(op, t)};
    endfunction

    always @(negedge clk) begin
        int n;
        n = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
        checks++;
        if (n > 1) begin
            errors++;
            $display("FAIL bus_drivers t=%0t drivers=%0d required<=1", $time, n);
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        ir_opcode = LDA;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(19'b0);
            @(negedge clk);
            exp_w = sb_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL reset_hold got=%h required=%h", obs, exp_w);
            end
        end
        reset = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            sb_q.push_back(exp_word(LDA, t));
            @(negedge clk);
            exp_w = sb_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL reset_release T%0d got=%h required=%h", t, obs, exp_w);
            end
        end
    endtask

    task automatic test_lda();
        int cp_cnt;
        cp_cnt = 0;
        ir_opcode = LDA;
        for (int k = 0; k < 12; k++) begin
            sb_q.push_back(exp_word(LDA, (k % 6) + 1));
            @(negedge clk);
            if (cp) cp_cnt++;
            exp_w = sb_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL lda T%0d got=%h required=%h", (k % 6) + 1, obs, exp_w);
            end
        end
        checks++;
        if (cp_cnt !== 2) begin
            errors++;
            $display("FAIL lda_cp_count got=%0d required=2", cp_cnt);
        end
    endtask

    task automatic test_add_sub();
        logic [3:0] ops [2];
        ops[0] = ADD;
        ops[1] = SUB;
        for (int i = 0; i < 2; i++) begin
            ir_opcode = ops[i];
            for (int t = 1; t <= 6; t++) begin
                sb_q.push_back(exp_word(ops[i], t));
                @(negedge clk);
                exp_w = sb_q.pop_front();
                checks++;
                if (obs !== exp_w) begin
                    errors++;
                    $display("FAIL add_sub op=%b T%0d got=%h required=%h", ops[i], t, obs, exp_w);
                end
            end
        end
    endtask

    task automatic test_out_nop();
        logic [3:0] ops [2];
        ops[0] = OUT;
        ops[1] = NOP;
        for (int i = 0; i < 2; i++) begin
            ir_opcode = ops[i];
            for (int t = 1; t <= 6; t++) begin
                sb_q.push_back(exp_word(ops[i], t));
                @(negedge clk);
                exp_w = sb_q.pop_front();
                checks++;
                if (obs !== exp_w) begin
                    errors++;
                    $display("FAIL out_nop op=%b T%0d got=%h required=%h", ops[i], t, obs, exp_w);
                end
            end
        end
    endtask

    task automatic test_hlt();
        ir_opcode = HLT;
        for (int k = 1; k <= 26; k++) begin
            sb_q.push_back(k <= 4 ? exp_word(HLT, k) : {1'b1, 6'b0, 12'b0});
            @(negedge clk);
            exp_w = sb_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL hlt cycle%0d got=%h required=%h", k, obs, exp_w);
            end
        end
        reset = 1'b0;
        #2;
        checks++;
        if (obs !== 19'b0) begin
            errors++;
            $display("FAIL hlt_reset got=%h required=%h", obs, 19'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        ir_opcode = LDA;
        sb_q.push_back(exp_word(LDA, 1));
        @(negedge clk);
        exp_w = sb_q.pop_front();
        checks++;
        if (obs !== exp_w) begin
            errors++;
            $display("FAIL hlt_restart got=%h required=%h", obs, exp_w);
        end
    endtask

    task automatic test_reset_mid_add();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ir_opcode = ADD;
        for (int t = 1; t <= 4; t++) begin
            sb_q.push_back(exp_word(ADD, t));
            @(negedge clk);
            exp_w = sb_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL mid_add T%0d got=%h required=%h", t, obs, exp_w);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (obs !== exp_word(ADD, 5)) begin
            errors++;
            $display("FAIL mid_add_t5 got=%h required=%h", obs, exp_word(ADD, 5));
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 19'b0) begin
            errors++;
            $display("FAIL mid_add_async_drop got=%h required=%h", obs, 19'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        sb_q.push_back(exp_word(ADD, 1));
        @(negedge clk);
        exp_w = sb_q.pop_front();
        checks++;
        if (obs !== exp_w) begin
            errors++;
            $display("FAIL mid_add_restart got=%h required=%h", obs, exp_w);
        end
    endtask

`ifdef SAP1_SINGLE_STEP_EN
    task automatic test_single_step();
        int adv, hits;
        logic [5:0] prev_t;
        reset = 1'b0;
        step = 1'b0;
        ir_opcode = LDA;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            adv = 0;
            hits = 0;
            prev_t = t_state;
            step = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (t_state !== prev_t) adv++;
                prev_t = t_state;
                if (pass == 0 ? ep : cp) hits++;
            end
            checks++;
            if (adv !== 1) begin
                errors++;
                $display("FAIL step_advances pass%0d got=%0d required=1", pass, adv);
            end
            checks++;
            if (hits !== 1) begin
                errors++;
                $display("FAIL step_pulse_width pass%0d got=%0d required=1", pass, hits);
            end
            checks++;
            if (t_state !== (pass == 0 ? 6'b000001 : 6'b000010)) begin
                errors++;
                $display("FAIL step_t_state pass%0d got=%b", pass, t_state);
            end
            step = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask
`endif

    initial begin
`ifdef SAP1_SINGLE_STEP_EN
        test_single_step();
`else
        test_reset();
        test_lda();
        test_add_sub();
        test_out_nop();
        test_hlt();
        test_reset_mid_add();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
